// File: rtl/mmio_timer_if.sv
// Bus bundle for the memory-mapped timer: the same signals the CPU presents
// to data_ram (chip enable, write enable, byte address, byte lanes, write
// data) plus the combinational read data returned by the peripheral.
interface mmio_timer_if;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (
        output ce, we, addr, sel, data_i,
        input  data_o
    );

    modport slave (
        input  ce, we, addr, sel, data_i,
        output data_o
    );
endinterface

// File: rtl/mmio_timer.sv
// 32-bit timer/compare peripheral on the data-RAM bus.
// Four registers selected by addr[3:2]: CTRL, COUNT, COMPARE, STATUS.
// A prescaler divides the clock into ticks; each tick advances COUNT and
// compares it against COMPARE, raising MATCH (and irq_o when IE is set).
module mmio_timer #(
    parameter int          PRESCALE_W  = 8,
    parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         rst,
    mmio_timer_if.slave  bus,
    output logic         irq_o
);

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_COUNT   = 2'd1;
    localparam logic [1:0] REG_COMPARE = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam logic [PRESCALE_W-1:0] PCNT_ONE = 1;

    // Architectural state
    logic                  en_reg, en_next;
    logic                  ar_reg, ar_next;
    logic                  ie_reg, ie_next;
    logic [PRESCALE_W-1:0] presc_reg, presc_next;
    logic [PRESCALE_W-1:0] pcnt_reg, pcnt_next;
    logic [31:0]           count_reg, count_next;
    logic [31:0]           compare_reg, compare_next;
    logic                  match_reg, match_next;

    // Bus decode
    logic        wr_en;
    logic        rd_en;
    logic [1:0]  reg_idx;
    logic        wr_ctrl;
    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;
    logic [31:0] wr_mask;

    // Register views and merged write values
    logic [31:0] ctrl_word;
    logic [31:0] ctrl_wr_word;
    logic [31:0] count_wr_word;
    logic [31:0] compare_wr_word;

    // Timer events
    logic tick;
    logic hit;

    assign wr_en      = bus.ce & bus.we;
    assign rd_en      = bus.ce & ~bus.we;
    assign reg_idx    = bus.addr[3:2];
    assign wr_ctrl    = wr_en && (reg_idx == REG_CTRL);
    assign wr_count   = wr_en && (reg_idx == REG_COUNT);
    assign wr_compare = wr_en && (reg_idx == REG_COMPARE);
    assign wr_status  = wr_en && (reg_idx == REG_STATUS);

    // Expand each byte-lane enable into a bit mask over its byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wr_mask[gi*8 +: 8] = {8{bus.sel[gi]}};
        end
    endgenerate

    // CTRL as seen by software; unimplemented bits read zero.
    always_comb begin
        ctrl_word                     = '0;
        ctrl_word[0]                  = en_reg;
        ctrl_word[1]                  = ar_reg;
        ctrl_word[2]                  = ie_reg;
        ctrl_word[8 +: PRESCALE_W]    = presc_reg;
    end

    assign ctrl_wr_word    = (ctrl_word   & ~wr_mask) | (bus.data_i & wr_mask);
    assign count_wr_word   = (count_reg   & ~wr_mask) | (bus.data_i & wr_mask);
    assign compare_wr_word = (compare_reg & ~wr_mask) | (bus.data_i & wr_mask);

    // A tick fires when the running prescaler reaches the programmed divide.
    // The compare always uses the pre-edge COMPARE, so a same-cycle COMPARE
    // write does not affect this tick.
    assign tick = en_reg && (pcnt_reg == presc_reg);
    assign hit  = tick && (count_reg == compare_reg);

    // Next-state logic for all registers, bus writes taking priority over ticks.
    always_comb begin
        en_next      = en_reg;
        ar_next      = ar_reg;
        ie_next      = ie_reg;
        presc_next   = presc_reg;
        pcnt_next    = pcnt_reg;
        count_next   = count_reg;
        compare_next = compare_reg;
        match_next   = match_reg;

        if (wr_ctrl) begin
            en_next    = ctrl_wr_word[0];
            ar_next    = ctrl_wr_word[1];
            ie_next    = ctrl_wr_word[2];
            presc_next = ctrl_wr_word[8 +: PRESCALE_W];
        end

        // Prescaler runs only while enabled; disabling through CTRL zeroes it
        // at the same edge, while a PRESC change leaves the count alone.
        if (!en_reg || tick) begin
            pcnt_next = '0;
        end else begin
            pcnt_next = pcnt_reg + PCNT_ONE;
        end
        if (wr_ctrl && !ctrl_wr_word[0]) begin
            pcnt_next = '0;
        end

        // A COUNT write discards both the tick increment and its match.
        if (wr_count) begin
            count_next = count_wr_word;
        end else if (tick) begin
            if (hit && ar_reg) begin
                count_next = '0;
            end else begin
                count_next = count_reg + 32'd1;
            end
        end

        if (wr_compare) begin
            compare_next = compare_wr_word;
        end

        // Setting MATCH beats a simultaneous write-1-to-clear.
        if (hit && !wr_count) begin
            match_next = 1'b1;
        end else if (wr_status && bus.sel[0] && bus.data_i[0]) begin
            match_next = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_reg      <= 1'b0;
            ar_reg      <= 1'b0;
            ie_reg      <= 1'b0;
            presc_reg   <= '0;
            pcnt_reg    <= '0;
            count_reg   <= '0;
            compare_reg <= COMPARE_RST;
            match_reg   <= 1'b0;
        end else begin
            en_reg      <= en_next;
            ar_reg      <= ar_next;
            ie_reg      <= ie_next;
            presc_reg   <= presc_next;
            pcnt_reg    <= pcnt_next;
            count_reg   <= count_next;
            compare_reg <= compare_next;
            match_reg   <= match_next;
        end
    end

    // Combinational read mux; idle or write cycles return zero.
    always_comb begin
        bus.data_o = '0;
        if (rd_en) begin
            case (reg_idx)
                REG_CTRL:    bus.data_o = ctrl_word;
                REG_COUNT:   bus.data_o = count_reg;
                REG_COMPARE: bus.data_o = compare_reg;
                default:     bus.data_o = {31'b0, match_reg};
            endcase
        end
    end

    assign irq_o = match_reg & ie_reg;

    // Address bits outside [3:2] and the non-field CTRL write bits are
    // intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], ctrl_wr_word};

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped 32-bit timer/compare peripheral on the CPU data-RAM bus, beside `data_ram`. It takes the same bus signals as `data_ram`: ce, we, addr, byte sel and write data, with combinational read data. The system decoder steers ce here. Its `irq_o` drives bit 1 of the 6-bit `interrupt` vector fed to `cpu_path`, alongside the CP0 timer interrupt on bit 0.

## Interface
- `PRESCALE_W`, 8: width of the prescaler field and prescaler counter.
- `COMPARE_RST`, 32'hFFFF_FFFF: reset value of COMPARE.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `ce` in 1: chip enable from the bus decoder.
- `we` in 1: write enable; qualified by `ce`.
- `addr` in 32: byte address; only `addr[3:2]` is decoded, all other bits are ignored.
- `sel` in 4: byte-lane enables; `sel[3]` maps to `data_i[31:24]` … `sel[0]` maps to `data_i[7:0]`.
- `data_i` in 32: write data.
- `data_o` out 32: read data, combinational.
- `irq_o` out 1: level interrupt request.

## Operation
- Register map, selected by `addr[3:2]`:
  - 0: CTRL.
    - bit0 EN.
    - bit1 AR (auto-reload).
    - bit2 IE.
    - bits[8+PRESCALE_W-1:8] PRESC.
    - All other bits read 0.
  - 1: COUNT, 32-bit read/write.
  - 2: COMPARE, 32-bit read/write.
  - 3: STATUS.
    - bit0 MATCH; write-1-to-clear.
    - Other bits read 0.
- Reset values:
  - CTRL = 0, COUNT = 0, COMPARE = `COMPARE_RST`.
  - MATCH = 0, prescaler counter = 0.
  - `irq_o` = 0.
  - `data_o` = 0 (because `ce` is expected low in reset; `data_o` is combinational).
- Writes happen when `ce & we` at a clock edge.
  - Each byte lane is updated only if its `sel` bit is set.
  - STATUS: clearing applies only to bit0, and only when `sel[0]=1` and `data_i[0]=1`.
- Reads: `data_o` = selected register when `ce & ~we`, otherwise 0.
- Prescaler, while EN=1:
  - The counter increments every cycle.
  - When counter == PRESC, a tick is generated and the counter returns to 0.
  - PRESC=0 gives a tick every cycle.
- EN=0: the prescaler counter is held at 0 and no ticks occur.
- On a tick, compare COUNT with COMPARE:
  - COUNT == COMPARE: MATCH <= 1. COUNT <= 0 if AR=1, else COUNT <= COUNT+1.
  - Otherwise: COUNT <= COUNT+1.
  - Arithmetic is modulo 2^32, so 0xFFFF_FFFF wraps to 0 with no flag.
- `irq_o` = MATCH & IE, a combinational function of registers. It therefore rises in the cycle after the edge that sets MATCH.
- Simultaneous events:
  - Bus write to COUNT in a tick cycle: the write wins; the tick's increment and its match detection are discarded.
  - Bus write to COMPARE in a tick cycle: the tick compares against the old COMPARE value.
  - MATCH set and W1C in the same cycle: set wins, MATCH stays 1.
  - Write to CTRL that clears EN: the prescaler counter is zeroed at that edge. A tick from the pre-write state is still processed in that cycle.
  - Write to CTRL that changes PRESC: takes effect from the next cycle; the counter is not reset.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); `irq_o` drops without waiting for a clock.

## Timing
- Read latency 0: `data_o` is valid in the same cycle `ce` is asserted, as with `data_ram`.
- Write latency 1: the new value is visible on the edge where `ce & we` is sampled.
- With EN set at edge E, PRESC=P:
  - First tick occurs in the cycle when the counter reaches P.
  - COUNT first changes at edge E+P+1.
  - Each subsequent tick is P+1 cycles after the previous one.
- Match to IRQ: the edge that sets MATCH is followed by `irq_o` high in the same cycle after that edge, i.e. 0 extra cycles of combinational delay.
- There is no handshake or wait state; every access completes in one cycle.

## Test plan
- Reset check:
  - Stimulus: assert `rst` asynchronously mid-cycle, then read all 4 registers.
  - Required: CTRL=0, COUNT=0, COMPARE=0xFFFF_FFFF, STATUS=0, `irq_o`=0.
- Free run:
  - Stimulus: PRESC=0, COMPARE=5, CTRL=0x5 (EN, IE).
  - Required: COUNT reads 1, 2, … on successive cycles. MATCH and `irq_o` rise after the tick at COUNT=5, and COUNT reads 6 next. Writing STATUS=1 drops `irq_o` on the next edge.
- Auto-reload with prescale:
  - Stimulus: PRESC=3, COMPARE=2, CTRL=0x307 (PRESC=3, EN, AR, IE).
  - Required: COUNT steps every 4 cycles through 0, 1, 2, 0. MATCH is set on the 2→0 transition.
- Byte lanes:
  - Stimulus: COUNT=0 with EN=0; write 0xAABBCCDD with `sel`=4'b0101.
  - Required: COUNT reads 0x00BB00DD.
- Collisions:
  - Stimulus 1: in a cycle where COUNT==COMPARE and a tick occurs, write COUNT=0x10.
  - Required 1: COUNT=0x10 and MATCH stays 0.
  - Stimulus 2: in a MATCH-set cycle, also W1C STATUS.
  - Required 2: MATCH=1.
- Wrap:
  - Stimulus: COUNT=0xFFFF_FFFE, COMPARE=3, EN, PRESC=0.
  - Required: COUNT reads 0xFFFF_FFFF, then 0, 1, 2, 3, 4. MATCH is set only at the tick where COUNT was 3.
